// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared FSM state, field helpers and iteration count for the float divider; FP_DIV_ROUND_NEAREST_EN enables round-to-nearest-even
package fp_div_pkg;
  typedef enum logic [1:0] {IDLE, DIV, NORM} fsmState_t;
`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif
  // Rounding needs one extra quotient bit to act as the guard bit
  localparam int ITER_EXTRA = ROUND_EN ? 1 : 0;
  function automatic int divIters(input int nbMant);
    return nbMant + 2 + ITER_EXTRA;
  endfunction
  function automatic int expBias(input int nbExpo);
    return ((1 << nbExpo) - 1) >> 1;
  endfunction
  function automatic logic [31:0] getMant(input logic [31:0] d, input int nbMant);
    return d & ((32'd1 << nbMant) - 32'd1);
  endfunction
  function automatic logic [31:0] getExpo(input logic [31:0] d, input int nbMant, input int nbExpo);
    return (d >> nbMant) & ((32'd1 << nbExpo) - 32'd1);
  endfunction
  function automatic logic [31:0] getSign(input logic [31:0] d, input int nbMant, input int nbExpo, input int nbSign);
    return (d >> (nbMant + nbExpo)) & ((32'd1 << nbSign) - 32'd1);
  endfunction
endpackage

// File: rtl/fp_mant_div_iter.sv
// fp_mant_div_iter: restoring mantissa divider, one quotient bit per enabled cycle
module fp_mant_div_iter #(
  parameter int NB_MANT = 8,
  parameter int ITERS = NB_MANT + 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_enable,
  input  logic [NB_MANT:0]   i_dividend,
  input  logic [NB_MANT:0]   i_divisor,
  output logic [ITERS-1:0]   o_quotient,
  output logic               o_remNonZero
);
  logic [NB_MANT+1:0] rem;
  logic [NB_MANT:0] dvs;
  logic geq;
  assign geq = rem >= {1'b0, dvs};
  assign o_remNonZero = |rem;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rem <= '0;
      dvs <= '0;
      o_quotient <= '0;
    end else if (i_load) begin
      rem <= {1'b0, i_dividend};
      dvs <= i_divisor;
      o_quotient <= '0;
    end else if (i_enable) begin
      rem <= (geq ? rem - {1'b0, dvs} : rem) << 1;
      o_quotient <= {o_quotient[ITERS-2:0], geq};
    end
  end
endmodule

// File: rtl/floating_point_divider_seq.sv
// floating_point_divider_seq: sequential {sign,exponent,mantissa} float divider; FP_DIV_ROUND_NEAREST_EN selects round-to-nearest-even
module floating_point_divider_seq
  import fp_div_pkg::*;
#(
  parameter int NB_SIGN = 1,
  parameter int NB_EXPO = 4,
  parameter int NB_MANT = 8
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_start,
  input  logic [NB_SIGN+NB_EXPO+NB_MANT-1:0] i_dataA,
  input  logic [NB_SIGN+NB_EXPO+NB_MANT-1:0] i_dataB,
  output logic [NB_SIGN+NB_EXPO+NB_MANT-1:0] o_data,
  output logic                               o_valid,
  output logic                               o_busy,
  output logic                               o_dbz,
  output logic                               o_ovf,
  output logic                               o_unf
);
  localparam int NB_DATA = NB_SIGN + NB_EXPO + NB_MANT;
  localparam int ITERS = divIters(NB_MANT);
  localparam int NB_FRAC = ITERS - 1;
  localparam int NB_EXT = NB_EXPO + 2;
  localparam int NB_CNT = $clog2(ITERS);
  localparam logic [NB_EXT-1:0] BIAS_EXT = NB_EXT'(expBias(NB_EXPO));
  localparam logic signed [NB_EXT-1:0] EXP_MAX = NB_EXT'((1 << NB_EXPO) - 1);
  fsmState_t state;
  logic [NB_CNT-1:0] iterCnt;
  logic [NB_SIGN-1:0] sgn;
  logic zeroA, zeroB, startOk, remNonZero;
  logic signed [NB_EXT-1:0] expRaw, expN;
  logic [ITERS-1:0] quo;
  logic [NB_FRAC-1:0] norm;
  logic [NB_MANT-1:0] mantT, mantR;
  logic guard, sticky, roundUp, carry, ovf, unf;
  logic [NB_DATA-1:0] result;
  assign startOk = state == IDLE && i_start;
  fp_mant_div_iter #(.NB_MANT(NB_MANT), .ITERS(ITERS)) uIter (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (startOk),
    .i_enable     (state == DIV),
    .i_dividend   ({1'b1, NB_MANT'(getMant(32'(i_dataA), NB_MANT))}),
    .i_divisor    ({1'b1, NB_MANT'(getMant(32'(i_dataB), NB_MANT))}),
    .o_quotient   (quo),
    .o_remNonZero (remNonZero)
  );
  // Quotient lies in (0.5, 2): a clear integer bit means shift left and borrow one from the exponent
  always_comb begin
    norm = quo[ITERS-1] ? quo[NB_FRAC-1:0] : {quo[NB_FRAC-2:0], 1'b0};
    mantT = norm[NB_FRAC-1 -: NB_MANT];
    guard = norm[NB_FRAC-1-NB_MANT];
    sticky = remNonZero || (|(norm << (NB_MANT + 1)));
    roundUp = ROUND_EN && guard && (sticky || mantT[0]);
    {carry, mantR} = {1'b0, mantT} + (NB_MANT + 1)'(roundUp);
    expN = expRaw - NB_EXT'(!quo[ITERS-1]) + NB_EXT'(carry);
    ovf = !zeroB && !zeroA && expN > EXP_MAX;
    unf = !zeroB && !zeroA && !ovf && expN <= 0;
    result = (zeroB || ovf) ? {sgn, {(NB_EXPO + NB_MANT){1'b1}}} :
             (zeroA || unf) ? {sgn, {(NB_EXPO + NB_MANT){1'b0}}} :
             {sgn, expN[NB_EXPO-1:0], mantR};
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      iterCnt <= '0;
      sgn <= '0;
      zeroA <= 1'b0;
      zeroB <= 1'b0;
      expRaw <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      o_dbz <= 1'b0;
      o_ovf <= 1'b0;
      o_unf <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state <= DIV;
          o_busy <= 1'b1;
          iterCnt <= '0;
          sgn <= NB_SIGN'(getSign(32'(i_dataA), NB_MANT, NB_EXPO, NB_SIGN)) ^
                 NB_SIGN'(getSign(32'(i_dataB), NB_MANT, NB_EXPO, NB_SIGN));
          zeroA <= getExpo(32'(i_dataA), NB_MANT, NB_EXPO) == 32'd0;
          zeroB <= getExpo(32'(i_dataB), NB_MANT, NB_EXPO) == 32'd0;
          expRaw <= NB_EXT'(getExpo(32'(i_dataA), NB_MANT, NB_EXPO)) -
                    NB_EXT'(getExpo(32'(i_dataB), NB_MANT, NB_EXPO)) + BIAS_EXT;
        end
        DIV: begin
          iterCnt <= iterCnt + 1'b1;
          if (iterCnt == NB_CNT'(ITERS - 1)) state <= NORM;
        end
        default: begin
          state <= IDLE;
          o_busy <= 1'b0;
          o_valid <= 1'b1;
          o_data <= result;
          o_dbz <= zeroB;
          o_ovf <= ovf;
          o_unf <= unf;
        end
      endcase
    end
  end
endmodule
